// File: rtl/fifo_rd_drain_if.sv
// fifo_rd_drain_if: the FIFO read port and UART TX request signals that the
// drain block uses to move words from the FIFO into the transmitter.
//
// Handshake rules:
//   FIFO side : RD_DATA is valid whenever RD_EMPTY=0. The FIFO pops the
//               current word on the R_CLK edge where RD_INC=1. RD_INC is
//               never high while RD_EMPTY=1.
//   UART side : TX_VALID is a one-cycle request with TX_DATA stable in that
//               cycle. The transmitter accepts the word by raising TX_BUSY
//               and drops TX_BUSY when it is done.
//
// Signals:
//   RD_EMPTY  FIFO empty flag            (slave -> master)
//   RD_DATA   FIFO word at read address  (slave -> master)
//   RD_INC    pop strobe                 (master -> slave)
//   TX_BUSY   UART TX busy               (slave -> master)
//   TX_DATA   word presented to UART TX  (master -> slave)
//   TX_VALID  one-cycle TX request       (master -> slave)
// Modports: master = drain block, slave = FIFO read port plus UART TX.
interface fifo_rd_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RD_EMPTY;
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic                  RD_INC;
  logic                  TX_BUSY;
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  TX_VALID;

  modport master (
    input  RD_EMPTY, RD_DATA, TX_BUSY,
    output RD_INC, TX_DATA, TX_VALID
  );

  modport slave (
    output RD_EMPTY, RD_DATA, TX_BUSY,
    input  RD_INC, TX_DATA, TX_VALID
  );
endinterface

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-domain consumer of the asynchronous FIFO. Pops one word
// at a time and hands it to the UART transmitter through the valid/busy
// handshake described in fifo_rd_drain_if.
//
// Optional feature macro: FIFO_RD_DRAIN_TIMEOUT_EN
//   defined   : WAIT_BUSY aborts to IDLE after BUSY_TIMEOUT cycles without
//               TX_BUSY, setting the sticky TX_ERR flag; the word is dropped.
//   undefined : WAIT_BUSY waits indefinitely and TX_ERR is tied to 0.
//
// Ports:
//   R_CLK       read-domain clock, rising edge
//   R_RST_n     asynchronous active-low reset
//   DRAIN_EN    permits new pops, sampled only in IDLE
//   bus         fifo_rd_drain_if.master (FIFO read port + UART TX request)
//   DRAIN_BUSY  registered, high in any state other than IDLE
//   TX_ERR      sticky handshake-timeout flag
//   DBG_STATE   current FSM state (IDLE=0, SEND=1, WAIT_BUSY=2, WAIT_DONE=3)
module fifo_rd_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                  R_CLK,
  input  logic                  R_RST_n,
  input  logic                  DRAIN_EN,
  fifo_rd_drain_if.master       bus,
  output logic                  DRAIN_BUSY,
  output logic                  TX_ERR,
  output logic [1:0]            DBG_STATE
);

  if ((BUSY_TIMEOUT < 2) || (BUSY_TIMEOUT > 255)) begin : g_bad_timeout
    $error("fifo_rd_drain: BUSY_TIMEOUT must be within 2..255");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                state_q, state_nx;
  logic                  pop_ok;
  logic                  rd_inc;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_valid_q;
  logic                  drain_busy_q;

`ifdef FIFO_RD_DRAIN_TIMEOUT_EN
  logic [7:0]            to_cnt_q;
  logic                  to_hit;
  logic                  tx_err_q;
`endif

  assign pop_ok = DRAIN_EN & ~bus.RD_EMPTY & ~bus.TX_BUSY;

  always_comb begin
    state_nx = state_q;
    rd_inc   = 1'b0;
`ifdef FIFO_RD_DRAIN_TIMEOUT_EN
    to_hit   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pop_ok) begin
          rd_inc   = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        // TX_BUSY is deliberately ignored here; WAIT_BUSY sees it next cycle.
        state_nx = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.TX_BUSY) begin
          state_nx = WAIT_DONE;
`ifdef FIFO_RD_DRAIN_TIMEOUT_EN
        end else if (to_cnt_q == 8'(BUSY_TIMEOUT - 1)) begin
          // This cycle's increment would make the count reach BUSY_TIMEOUT.
          to_hit   = 1'b1;
          state_nx = IDLE;
`endif
        end
      end
      WAIT_DONE: begin
        if (!bus.TX_BUSY) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Gated by reset so no pop reaches the FIFO while the block is held.
  assign bus.RD_INC = rd_inc & R_RST_n;

  always_ff @(posedge R_CLK or negedge R_RST_n) begin
    if (!R_RST_n) begin
      state_q      <= IDLE;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      drain_busy_q <= 1'b0;
    end else begin
      state_q      <= state_nx;
      tx_valid_q   <= rd_inc;
      drain_busy_q <= (state_nx != IDLE);
      if (rd_inc) tx_data_q <= bus.RD_DATA;
    end
  end

`ifdef FIFO_RD_DRAIN_TIMEOUT_EN
  // Held at zero outside WAIT_BUSY, so it starts from zero on every entry.
  always_ff @(posedge R_CLK or negedge R_RST_n) begin
    if (!R_RST_n) begin
      to_cnt_q <= '0;
      tx_err_q <= 1'b0;
    end else begin
      if (state_q != WAIT_BUSY) to_cnt_q <= '0;
      else if (!bus.TX_BUSY)    to_cnt_q <= to_cnt_q + 8'd1;
      if (to_hit) tx_err_q <= 1'b1;
    end
  end

  assign TX_ERR = tx_err_q;
`else
  assign TX_ERR = 1'b0;
`endif

  assign bus.TX_DATA  = tx_data_q;
  assign bus.TX_VALID = tx_valid_q;
  assign DRAIN_BUSY   = drain_busy_q;
  assign DBG_STATE    = state_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: bench for fifo_rd_drain with a FIFO model, a reactive
// UART TX model and a scoreboard of expected TX words.
module tb_fifo_rd_drain;
  localparam int DW = 8;
  localparam int BT = 8;

  // ---------------- clock / reset ----------------
  logic       R_CLK   = 1'b0;
  logic       R_RST_n = 1'b0;
  logic       drain_en = 1'b0;
  logic       drain_busy;
  logic       tx_err;
  logic [1:0] dbg_state;

  always #5 R_CLK = ~R_CLK;

  fifo_rd_drain_if #(.DATA_WIDTH(DW)) bus ();

  fifo_rd_drain #(.DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
    .R_CLK      (R_CLK),
    .R_RST_n    (R_RST_n),
    .DRAIN_EN   (drain_en),
    .bus        (bus),
    .DRAIN_BUSY (drain_busy),
    .TX_ERR     (tx_err),
    .DBG_STATE  (dbg_state)
  );

  int cyc = 0;
  always @(posedge R_CLK) cyc <= cyc + 1;

  // ---------------- FIFO model ----------------
  logic [DW-1:0] mem [0:63];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  bit            direct = 1'b0;
  logic          dir_empty = 1'b1;
  logic [DW-1:0] dir_data = '0;

  always @(posedge R_CLK) if (bus.RD_INC === 1'b1) rd_ptr <= rd_ptr + 1;

  assign bus.RD_EMPTY = direct ? dir_empty : (rd_ptr == wr_ptr);
  assign bus.RD_DATA  = direct ? dir_data  : mem[rd_ptr % 64];

  // ---------------- UART TX model ----------------
  bit   tx_model_en = 1'b0;
  int   busy_k      = 10;
  int   busy_left   = 0;
  logic model_busy  = 1'b0;
  logic force_busy  = 1'b0;

  always @(posedge R_CLK) begin
    if (!tx_model_en) begin
      model_busy <= 1'b0;
      busy_left  <= 0;
    end else if (bus.TX_VALID === 1'b1) begin
      model_busy <= 1'b1;
      busy_left  <= busy_k - 1;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
    end else begin
      model_busy <= 1'b0;
    end
  end

  assign bus.TX_BUSY = model_busy | force_busy;

  // ---------------- scoreboard ----------------
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  int            pop_times[$];
  int            pop_count   = 0;
  int            valid_count = 0;
  logic          prev_inc    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  always @(negedge R_CLK) begin
    if (bus.TX_VALID === 1'b1) begin
      valid_count++;
      if (exp_q.size() == 0) fail("unexpected_tx_valid");
      else check("tx_data_sb", 32'(bus.TX_DATA), 32'(exp_q.pop_front()));
    end
    if (bus.RD_INC === 1'b1) begin
      pop_count++;
      pop_times.push_back(cyc);
      check("pop_not_empty", 32'(bus.RD_EMPTY), 32'd0);
      check("pop_in_idle",   32'(dbg_state),    32'd0);
      check("pop_not_busy",  32'(bus.TX_BUSY),  32'd0);
      check("pop_not_consec", 32'(prev_inc),    32'd0);
    end
    prev_inc = bus.RD_INC;
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [DW-1:0] d, input bit expect_tx);
    mem[wr_ptr % 64] = d;
    wr_ptr++;
    if (expect_tx) exp_q.push_back(d);
  endtask

  task automatic wait_pop(input string name);
    for (int i = 0; i < 30; i++) begin
      @(negedge R_CLK);
      if (bus.RD_INC === 1'b1) return;
    end
    fail(name);
  endtask

  task automatic wait_state(input logic [1:0] s, input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge R_CLK);
      if (dbg_state === s) return;
    end
    fail(name);
  endtask

  task automatic wait_drained(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge R_CLK);
      if ((rd_ptr == wr_ptr) && (drain_busy === 1'b0)) return;
    end
    fail(name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic  en;
    logic  empty;
    logic  busy;
    logic  rst_n;
    logic  exp_inc;
    string name;
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    int base_pop;
    int base_valid;
    int n;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "vec_pop"};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "vec_no_en"};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "vec_empty"};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "vec_tx_busy"};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "vec_all_off"};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "vec_in_reset"};

    // Reset values
    repeat (2) @(negedge R_CLK);
    check("rst_rd_inc",     32'(bus.RD_INC),   32'd0);
    check("rst_tx_valid",   32'(bus.TX_VALID), 32'd0);
    check("rst_tx_data",    32'(bus.TX_DATA),  32'd0);
    check("rst_drain_busy", 32'(drain_busy),   32'd0);
    check("rst_tx_err",     32'(tx_err),       32'd0);
    check("rst_state",      32'(dbg_state),    32'd0);

    // Table: combinational pop condition in IDLE; reset re-asserted before
    // every edge so no vector ever leaves IDLE.
    direct = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge R_CLK);
      #1;
      drain_en   = vecs[i].en;
      dir_empty  = vecs[i].empty;
      dir_data   = 8'h5A;
      force_busy = vecs[i].busy;
      R_RST_n    = vecs[i].rst_n;
      @(negedge R_CLK);
      check(vecs[i].name, 32'(bus.RD_INC), 32'(vecs[i].exp_inc));
      check("vec_drain_busy", 32'(drain_busy), 32'd0);
      #1;
      R_RST_n = 1'b0;
    end
    @(posedge R_CLK);
    #1;
    direct     = 1'b0;
    dir_empty  = 1'b1;
    force_busy = 1'b0;
    drain_en   = 1'b0;
    R_RST_n    = 1'b1;

    // Single word, TX busy for 10 cycles
    tx_model_en = 1'b1;
    busy_k      = 10;
    base_pop    = pop_count;
    base_valid  = valid_count;
    @(posedge R_CLK);
    #1;
    drain_en = 1'b1;
    push_word(8'hA5, 1'b1);
    wait_pop("single_pop");
    @(negedge R_CLK);
    check("single_valid_latency", 32'(bus.TX_VALID), 32'd1);
    check("single_tx_data",       32'(bus.TX_DATA),  32'hA5);
    n = 1;
    while ((drain_busy === 1'b1) && (n < 40)) begin
      @(negedge R_CLK);
      n++;
    end
    check("single_period", 32'(n), 32'd13);
    repeat (3) @(negedge R_CLK);
    check("single_pop_count",   32'(pop_count - base_pop),     32'd1);
    check("single_valid_count", 32'(valid_count - base_valid), 32'd1);

    // Burst of three, TX busy for 3 cycles -> 6-cycle word period
    busy_k     = 3;
    base_pop   = pop_count;
    base_valid = valid_count;
    pop_times.delete();
    @(posedge R_CLK);
    #1;
    push_word(8'h11, 1'b1);
    push_word(8'h22, 1'b1);
    push_word(8'h33, 1'b1);
    wait_drained("burst_drain");
    repeat (5) @(negedge R_CLK);
    check("burst_pop_count",   32'(pop_count - base_pop),     32'd3);
    check("burst_valid_count", 32'(valid_count - base_valid), 32'd3);
    check("burst_last_data",   32'(bus.TX_DATA),              32'h33);
    if (pop_times.size() == 3) begin
      check("burst_gap1", 32'(pop_times[1] - pop_times[0]), 32'd6);
      check("burst_gap2", 32'(pop_times[2] - pop_times[1]), 32'd6);
    end else begin
      fail("burst_pop_times");
    end

    // Gating: DRAIN_EN low with a non-empty FIFO
    busy_k   = 10;
    base_pop = pop_count;
    @(posedge R_CLK);
    #1;
    drain_en = 1'b0;
    push_word(8'h44, 1'b1);
    repeat (20) @(negedge R_CLK);
    check("gate_no_pop", 32'(pop_count - base_pop), 32'd0);
    @(posedge R_CLK);
    #1;
    drain_en = 1'b1;
    wait_pop("gate_pop");
    wait_state(2'd3, 20, "gate_wait_done");
    @(posedge R_CLK);
    #1;
    drain_en = 1'b0;
    push_word(8'h55, 1'b1);
    for (int i = 0; (i < 40) && (drain_busy === 1'b1); i++) @(negedge R_CLK);
    repeat (10) @(negedge R_CLK);
    check("gate_pop_count", 32'(pop_count - base_pop), 32'd1);
    check("gate_tx_data",   32'(bus.TX_DATA),          32'h44);
    check("gate_idle",      32'(drain_busy),           32'd0);

    // Reset during WAIT_DONE
    @(posedge R_CLK);
    #1;
    drain_en = 1'b1;
    wait_pop("rst_seq_pop");
    wait_state(2'd3, 20, "rst_seq_wait_done");
    #2;
    R_RST_n = 1'b0;
    #1;
    check("mid_rst_rd_inc",     32'(bus.RD_INC),   32'd0);
    check("mid_rst_tx_valid",   32'(bus.TX_VALID), 32'd0);
    check("mid_rst_tx_data",    32'(bus.TX_DATA),  32'd0);
    check("mid_rst_drain_busy", 32'(drain_busy),   32'd0);
    check("mid_rst_tx_err",     32'(tx_err),       32'd0);
    check("mid_rst_state",      32'(dbg_state),    32'd0);
    tx_model_en = 1'b0;
    @(posedge R_CLK);
    #1;
    push_word(8'h66, 1'b1);
    @(posedge R_CLK);
    #1;
    R_RST_n     = 1'b1;
    tx_model_en = 1'b1;
    @(negedge R_CLK);
    check("post_rst_pop", 32'(bus.RD_INC), 32'd1);
    wait_drained("post_rst_drain");
    check("post_rst_tx_data", 32'(bus.TX_DATA), 32'h66);

`ifdef FIFO_RD_DRAIN_TIMEOUT_EN
    // Timeout: TX never answers
    tx_model_en = 1'b0;
    @(posedge R_CLK);
    #1;
    push_word(8'h77, 1'b1);
    push_word(8'h88, 1'b1);
    wait_pop("to_pop1");
    n = 0;
    do begin
      @(negedge R_CLK);
      n++;
    end while ((dbg_state !== 2'd0) && (n < 40));
    check("to_return_cycles", 32'(n),           32'd10);
    check("to_err_set",       32'(tx_err),      32'd1);
    check("to_next_pop",      32'(bus.RD_INC),  32'd1);
    repeat (3) @(negedge R_CLK);
    check("to_err_sticky", 32'(tx_err), 32'd1);
    wait_drained("to_drain");
    check("to_err_sticky2", 32'(tx_err), 32'd1);
`else
    // No timeout: TX never answers, block waits indefinitely
    tx_model_en = 1'b0;
    @(posedge R_CLK);
    #1;
    push_word(8'h77, 1'b1);
    wait_pop("nto_pop");
    repeat (40) @(negedge R_CLK);
    check("nto_state",      32'(dbg_state),  32'd2);
    check("nto_tx_err",     32'(tx_err),     32'd0);
    check("nto_drain_busy", 32'(drain_busy), 32'd1);
`endif

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    fail("watchdog");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-domain consumer of the asynchronous FIFO. It pops one word at a time from the FIFO read port (empty flag, pop strobe, read data) and hands each word to the UART transmitter through a valid/busy handshake. It sits between the FIFO read side and the UART TX, clocked on the read/UART clock. It is the block that drives the FIFO pop strobe from the FIFO empty flag.

## Interface
Parameters:
- DATA_WIDTH, 8, width of the FIFO word and of TX_DATA
- BUSY_TIMEOUT, 8, cycles allowed in WAIT_BUSY before abort; used only with FIFO_RD_DRAIN_TIMEOUT_EN; legal range 2..255

Ports:
- R_CLK  in  1  read-domain clock; all state on rising edge
- R_RST_n  in  1  asynchronous, active-low reset
- DRAIN_EN  in  1  permits new pops; sampled only in IDLE
- RD_EMPTY  in  1  FIFO empty flag, same-cycle valid in R_CLK domain
- RD_DATA  in  DATA_WIDTH  FIFO word at the current read address; valid whenever RD_EMPTY=0
- RD_INC  out  1  pop strobe to FIFO; FIFO advances on the R_CLK edge where RD_INC=1
- TX_BUSY  in  1  UART TX busy, R_CLK domain
- TX_DATA  out  DATA_WIDTH  word presented to UART TX
- TX_VALID  out  1  one-cycle request to UART TX
- DRAIN_BUSY  out  1  high in any state other than IDLE
- TX_ERR  out  1  sticky handshake-timeout flag

## Operation
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE; 2-bit encoding; reset state IDLE.
- IDLE: pop condition = DRAIN_EN & ~RD_EMPTY & ~TX_BUSY. When it holds:
  - RD_INC=1 (combinational, this cycle only).
  - TX_DATA <= RD_DATA on the same edge.
  - TX_VALID <= 1; next state SEND.
- SEND: TX_VALID=1 for exactly this cycle. At the edge, TX_VALID <= 0 and next state is WAIT_BUSY.
- WAIT_BUSY:
  - TX_BUSY=1 -> WAIT_DONE.
  - Otherwise stay.
  - With the timeout macro: abort to IDLE after BUSY_TIMEOUT cycles (see Configuration).
- WAIT_DONE: TX_BUSY=0 -> IDLE. Otherwise stay; no timeout.
- RD_INC = (state==IDLE) & pop condition & R_RST_n. It is never high outside IDLE, never high for two consecutive cycles, and never high while RD_EMPTY=1.
- TX_DATA holds its value until the next pop and is never cleared except by reset.
- DRAIN_EN deasserted mid-transfer: the current word completes normally; only the next pop is blocked.
- RD_EMPTY rising after a pop: no effect on the transfer in flight.
- Reset asserted in any state:
  - Immediately: state=IDLE, TX_VALID=0, TX_DATA=0, TX_ERR=0, DRAIN_BUSY=0, RD_INC=0.
  - A word in flight is lost. A word already popped is not re-read.
- TX_ERR is cleared only by reset.

## Timing
- Reset values: TX_DATA=0, TX_VALID=0, RD_INC=0, DRAIN_BUSY=0, TX_ERR=0.
- Pop-to-valid latency: 1 cycle. TX_VALID is high in the cycle after RD_INC.
- DRAIN_BUSY is registered (state != IDLE). It rises in the cycle after the pop.
- With TX_BUSY rising 1 cycle after TX_VALID and staying high for K cycles, the per-word period is K+3 cycles: IDLE, SEND, WAIT_BUSY, K-1 WAIT_DONE cycles seeing busy, then 1 WAIT_DONE cycle seeing ~busy.
- Back-to-back words: the next RD_INC comes in the first IDLE cycle after TX_BUSY falls, provided RD_EMPTY=0 and DRAIN_EN=1.
- TX_BUSY high during SEND: ignored. WAIT_BUSY sees it on the next cycle and moves straight to WAIT_DONE.

## Configuration
- Macro: FIFO_RD_DRAIN_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to WAIT_BUSY and increments each WAIT_BUSY cycle with TX_BUSY=0.
  - When the count reaches BUSY_TIMEOUT, the next state is IDLE and TX_ERR <= 1.
  - The popped word is dropped and not retried.
- Undefined:
  - No counter. WAIT_BUSY waits indefinitely.
  - TX_ERR is tied to 0.

## Test plan
- Single word: reset, then RD_EMPTY=0, RD_DATA=0xA5, DRAIN_EN=1, TX model raises busy 1 cycle after valid for 10 cycles -> exactly one RD_INC pulse, TX_DATA=0xA5, one TX_VALID pulse in the next cycle, DRAIN_BUSY low 13 cycles after the pop.
- Burst: FIFO model holds 0x11, 0x22, 0x33 -> three RD_INC pulses, TX_DATA sequence 0x11, 0x22, 0x33, no pop while TX_BUSY=1, no RD_INC after the FIFO reports empty.
- Gating: DRAIN_EN=0 with non-empty FIFO for 20 cycles -> RD_INC stays 0. Drop DRAIN_EN during WAIT_DONE -> the current word completes and no further pop occurs.
- Reset mid-transfer: assert R_RST_n=0 during WAIT_DONE -> all outputs return to 0 immediately. After release with FIFO non-empty, a pop occurs in the first IDLE cycle.
- Timeout (macro defined, BUSY_TIMEOUT=8): TX_BUSY held 0 -> return to IDLE 8 cycles after entering WAIT_BUSY, TX_ERR=1 and sticky, the next word is popped. With the macro undefined, the block stays in WAIT_BUSY and TX_ERR=0.
